// File: rtl/decode_pkg.sv
// Shared decode-side types: instruction buffer entries, buffer FSM states,
// and the MIPS opcode/funct values that mark control-transfer instructions.
package decode_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pcplus4;
        logic  is_ctrl;
    } ibuf_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        WAIT_DS = 1'b1
    } ibuf_state_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

endpackage

// File: rtl/decode_ibuf_predecode.sv
// Combinational predecode: flags branches and jumps so the buffer can
// mark the following instruction as a delay slot.
module predecode
    import decode_pkg::*;
(
    input  word_t raw_instr,
    output logic  is_ctrl
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_bits;

    assign op          = raw_instr[31:26];
    assign funct       = raw_instr[5:0];
    assign unused_bits = ^raw_instr[25:6];

    always_comb begin
        is_ctrl = 1'b0;
        case (op)
            OP_REGIMM, OP_J, OP_JAL,
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_ctrl = 1'b1;
            OP_SPECIAL: is_ctrl = (funct == FN_JR) || (funct == FN_JALR);
            default:    is_ctrl = 1'b0;
        endcase
    end

endmodule

// File: rtl/decode_ibuf.sv
// Fetch-to-decode instruction buffer: multi-wide enqueue, single dequeue,
// delay-slot flag generation and delay-slot-preserving redirect.
module decode_ibuf
    import decode_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FETCH_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [FETCH_WIDTH-1:0]    enq_valid,
    input  logic [32*FETCH_WIDTH-1:0] enq_instr,
    input  logic [31:0]               enq_pc,
    output logic                      enq_ready,
    output logic                      deq_valid,
    output logic [31:0]               deq_instr,
    output logic [31:0]               deq_pcplus4,
    output logic                      deq_in_delay_slot,
    input  logic                      deq_ready,
    input  logic                      redirect,
    input  logic                      flush
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]       wr_ptr, rd_ptr, wr_n, rd_n, count;
    ibuf_state_t            state, state_n;
    logic                   last_ctrl, last_ctrl_n;
    logic                   enq_fire, deq_fire;
    logic [FETCH_WIDTH-1:0] we, slot_ctrl;
    logic [IDX_W-1:0]       widx [FETCH_WIDTH];
    ibuf_entry_t            slot_e [FETCH_WIDTH];
    ibuf_entry_t            mem [DEPTH];
    ibuf_entry_t            head;

    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
        predecode u_pd (
            .raw_instr (enq_instr[32*k +: 32]),
            .is_ctrl   (slot_ctrl[k])
        );
        assign slot_e[k] = '{
            instr:   enq_instr[32*k +: 32],
            pcplus4: enq_pc + 32'(4*k + 4),
            is_ctrl: slot_ctrl[k]
        };
        assign widx[k] = wr_ptr[IDX_W-1:0] + IDX_W'(k);
    end

    assign count     = wr_ptr - rd_ptr;
    assign head      = mem[rd_ptr[IDX_W-1:0]];
    assign deq_valid = (count != '0);
    assign deq_fire  = deq_valid & deq_ready;
    assign enq_ready = (state == WAIT_DS) ||
                       (count <= PTR_W'(DEPTH - FETCH_WIDTH));
    assign enq_fire  = enq_ready & enq_valid[0];

    assign deq_instr         = deq_valid ? head.instr : '0;
    assign deq_pcplus4       = deq_valid ? head.pcplus4 : '0;
    assign deq_in_delay_slot = deq_valid & last_ctrl;

    always_comb begin
        state_n     = state;
        wr_n        = wr_ptr;
        rd_n        = rd_ptr;
        last_ctrl_n = last_ctrl;
        we          = '0;
        if (flush) begin
            state_n     = RUN;
            wr_n        = '0;
            rd_n        = '0;
            last_ctrl_n = 1'b0;
        end else begin
            if (deq_fire) begin
                rd_n        = rd_ptr + PTR_W'(1);
                last_ctrl_n = head.is_ctrl;
            end
            if (state == WAIT_DS) begin
                if (enq_fire) begin
                    we      = FETCH_WIDTH'(1);
                    state_n = RUN;
                end
            end else if (redirect) begin
                // Only the delay slot survives; it is either popped now,
                // already at the head, arriving now, or still to come.
                if (deq_fire || deq_valid) begin
                    wr_n = rd_ptr + PTR_W'(1);
                end else if (enq_fire) begin
                    we = FETCH_WIDTH'(1);
                end else begin
                    state_n = WAIT_DS;
                end
            end else if (enq_fire) begin
                we = enq_valid;
            end
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                wr_n = wr_n + PTR_W'(we[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_ctrl <= 1'b0;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_n;
            rd_ptr    <= rd_n;
            last_ctrl <= last_ctrl_n;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (we[k]) mem[widx[k]] <= slot_e[k];
        end
    end

endmodule

// File: doc/decode_ibuf.md
# decode_ibuf

Parametrised instruction buffer between fetch and decode. It accepts up to FETCH_WIDTH instructions per cycle from fetch and hands one instruction per cycle to the decode stage. It generates the per-instruction in-delay-slot flag from a registered predecode of branch/jump opcodes. On a taken branch or jump it keeps exactly the architectural delay slot and discards all younger entries, including when the delay slot has not yet arrived.

## Interface
Parameters:
- DEPTH, 8: entry count; power of two, ≥ 4, ≥ 2·FETCH_WIDTH.
- FETCH_WIDTH, 2: instructions offered per cycle; 1 or 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enq_valid  in  FETCH_WIDTH  per-slot valid.
  - Must be thermometer: slot k valid implies slot k-1 valid.
- enq_instr  in  32·FETCH_WIDTH  raw instructions; slot k is bits [32k+31:32k].
- enq_pc  in  32  PC of slot 0; slot k PC = enq_pc + 4k.
- enq_ready  out  1  buffer accepts the whole enq bundle this cycle.
- deq_valid  out  1  head entry present.
- deq_instr  out  32  head raw instruction; 0 when deq_valid=0.
- deq_pcplus4  out  32  head PC+4; 0 when deq_valid=0.
- deq_in_delay_slot  out  1  head follows a branch/jump; 0 when deq_valid=0.
- deq_ready  in  1  decode consumes head (= ~stallD).
- redirect  in  1  instruction currently in decode is a taken branch or any jump.
- flush  in  1  exception flush; discard everything.

## Operation
- Enq fire: enq_ready & enq_valid[0]. The entries written are the valid slots, in slot order.
- Deq fire: deq_valid & deq_ready.
- enq_ready = (DEPTH − count ≥ FETCH_WIDTH), computed from the registered count. It does not count a same-cycle deq.
- Each entry stores {instr, pcplus4, is_ctrl}.
  - is_ctrl comes from predecode at enq time.
  - Control opcodes: 000010 J, 000011 JAL, 000100–000111 BEQ/BNE/BLEZ/BGTZ, and 000001 REGIMM.
  - Also SPECIAL (000000) with funct 001000 JR or 001001 JALR.
- last_ctrl register:
  - On deq fire, last_ctrl ← head.is_ctrl.
  - Cleared by reset and flush. Not cleared by redirect.
  - deq_in_delay_slot = deq_valid & last_ctrl.
- FSM states: RUN, WAIT_DS. Priority: reset > flush > redirect > normal.
- flush: count ← 0, pointers ← 0, last_ctrl ← 0, state ← RUN. Same-cycle enq and deq are ignored.
- redirect in RUN — the delay slot is the next instruction after the one in decode:
  - Deq fires this cycle: the popped head is the delay slot. All remaining entries and any same-cycle enq are dropped; count ← 0.
  - No deq, count ≥ 1: keep the head only (count ← 1). Same-cycle enq is dropped.
  - count = 0, enq fires this cycle: keep slot 0 only; discard other slots.
  - count = 0, no enq: state ← WAIT_DS.
- WAIT_DS:
  - enq_ready = 1.
  - The first enq fire writes slot 0 only, discards other slots, and returns to RUN.
  - redirect is ignored in this state.
  - flush returns to RUN.
- Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH. The MSB distinguishes full from empty. count = wr_ptr − rd_ptr.
- Enq bundle write wrap: slot 1 goes to index (wr+1) mod DEPTH.

## Timing
- Enqueued entries are visible at deq the cycle after the enq fire. There is no enq→deq bypass.
- deq_* outputs are combinational from head storage and registered state. No input-to-output combinational path except none: deq_ready affects state only.
- Simultaneous enq and deq in RUN: count ← count + n_enq − 1.
- Full buffer: enq_ready=0; deq still fires normally.
- Empty buffer: deq_valid=0; deq_ready is ignored.
- Reset values: deq_valid=0, deq_instr=0, deq_pcplus4=0, deq_in_delay_slot=0, enq_ready=1, state RUN, count 0.
- Reset mid-operation: all entries are discarded within the same edge.

## Structure
- Add to decode_pkg:
  - ibuf_entry_t {word_t instr; word_t pcplus4; logic is_ctrl;}
  - ibuf_state_t enum {RUN, WAIT_DS}
  - The control opcode/funct constants.
- Sub-module predecode: combinational, word_t raw_instr → logic is_ctrl. Instantiate one per fetch slot.
- Storage: ibuf_entry_t array [DEPTH]; no reset on array contents.

## Test plan
- Fill/drain, FETCH_WIDTH=2, DEPTH=8:
  - Enq 4 bundles of ADDIU, PCs 0x100..0x11C → enq_ready falls after the 4th bundle.
  - 8 pops return pcplus4 0x104..0x120 in order; deq_in_delay_slot all 0.
- Delay-slot flag:
  - Sequence BEQ@0x200, ADDU@0x204, ADDU@0x208 → flags 0, 1, 0.
  - Flush after the BEQ pop → next pop has flag 0.
- Redirect with delay slot buffered:
  - BNE popped; buffer holds 0x204, 0x208, 0x20C; redirect with deq_ready=0 → count 1.
  - Next pop returns pcplus4 0x208 with flag 1; then deq_valid=0.
- Redirect with empty buffer:
  - J popped, buffer empty, redirect → WAIT_DS.
  - Next bundle {0x304, 0x308} → only 0x304 is stored, flag 1; the following bundle at 0x400 is accepted normally.
- Redirect coinciding with deq of the delay slot:
  - Same-cycle enq bundle is dropped; count 0 afterwards.
- Wrap-around:
  - 20 cycles of random enq/deq with DEPTH=4, FETCH_WIDTH=1 → output order matches a reference queue.
  - Reset asserted mid-stream → deq_valid=0 the next cycle.
